// File: rtl/alu_operand_loader.sv
// alu_operand_loader: synchronises the slide switches and push-buttons,
// debounces the buttons and loads operand A, operand B and the op code on
// clean single-button presses. Once all three fields are loaded it raises
// o_valid for one cycle and clears the loaded flags. The operand values
// themselves are held for the ALU.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_switch         raw slide switches (LEN_DATO)
//   i_buttons        raw buttons: [2]=load A, [1]=load B, [0]=load OP
//   o_dato_a/b       operands to the ALU (LEN_DATO)
//   o_op_code        op code to the ALU (LEN_OP, from switch[LEN_OP-1:0])
//   o_loaded         sticky loaded flags {A,B,OP}
//   o_valid          one-cycle strobe once all three fields are loaded

// Per-button debounce lane: stable follows the synchronised input only after
// CYCLES consecutive cycles of disagreement.
module alu_operand_loader_debounce #(
  parameter int CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sync,
  output logic o_stable
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          stable_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (i_sync == stable_q) begin
      cnt_q    <= '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_q <= i_sync;
      cnt_q    <= '0;
    end else begin
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign o_stable = stable_q;
endmodule

module alu_operand_loader #(
  parameter int LEN_DATO        = 8,
  parameter int LEN_OP          = 6,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [LEN_DATO-1:0] i_switch,
  input  logic [2:0]          i_buttons,
  output logic [LEN_DATO-1:0] o_dato_a,
  output logic [LEN_DATO-1:0] o_dato_b,
  output logic [LEN_OP-1:0]   o_op_code,
  output logic [2:0]          o_loaded,
  output logic                o_valid
);
  localparam int NUM_BTN = 3;

  typedef enum logic {S_COLLECT = 1'b0, S_VALID = 1'b1} state_e;

  logic [LEN_DATO-1:0] sw_meta_q, sw_sync_q;
  logic [NUM_BTN-1:0]  btn_meta_q, btn_sync_q;
  logic [NUM_BTN-1:0]  stable, stable_prev_q, press, load;
  logic                one_hot;
  logic [LEN_DATO-1:0] dato_a_q, dato_b_q;
  logic [LEN_OP-1:0]   op_q;
  logic [NUM_BTN-1:0]  loaded_q, loaded_d;
  state_e              state_q, state_d;

  // two-flop synchronisers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      sw_meta_q  <= i_switch;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= i_buttons;
      btn_sync_q <= btn_meta_q;
    end
  end

  alu_operand_loader_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_sync   (btn_sync_q),
    .o_stable (stable)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stable_prev_q <= '0;
    else          stable_prev_q <= stable;
  end

  // A press only counts while exactly one button is held; press is a subset
  // of stable, so a one-hot stable also means a single press.
  assign press   = stable & ~stable_prev_q;
  assign one_hot = (stable == 3'b100) || (stable == 3'b010) || (stable == 3'b001);
  assign load    = one_hot ? press : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dato_a_q <= '0;
      dato_b_q <= '0;
      op_q     <= '0;
    end else begin
      if (load[2]) dato_a_q <= sw_sync_q;
      if (load[1]) dato_b_q <= sw_sync_q;
      if (load[0]) op_q     <= sw_sync_q[LEN_OP-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_COLLECT;
      loaded_q <= '0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
    end
  end

  // Flags clear on the S_VALID exit edge, but a load landing on that same
  // edge still sets its own flag.
  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q | load;
    case (state_q)
      S_COLLECT: if (loaded_q == 3'b111) state_d = S_VALID;
      S_VALID: begin
        state_d  = S_COLLECT;
        loaded_d = load;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  assign o_dato_a  = dato_a_q;
  assign o_dato_b  = dato_b_q;
  assign o_op_code = op_q;
  assign o_loaded  = loaded_q;
  assign o_valid   = (state_q == S_VALID);
endmodule
